alu_div_sequencer: RTL and testbench

//  Multi-cycle RV32M divide/remainder controller (DIV, DIVU, REM, REMU). Drives the shared
//  EX-stage ALU through 32 restoring trial-subtract iterations and reads its result and Carry flag.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/alu_div_sequencer.sv | 131 +++++++++++++
 tb/tb_alu_div_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 execute-stage constants: ALU control codes, M-extension divide ops
// and the divide sequencer state encoding.
package riscv_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

endpackage

// File: rtl/alu_div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU sequencer: runs 32 restoring trial-subtract steps
// on the shared EX-stage ALU, then sign-fixes and returns quotient or remainder.
module alu_div_sequencer
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  output logic [2:0]      alu_ctrl_o,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            alu_carry_i
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t       state_q, state_d;
  logic [1:0]       op_q;
  logic [XLEN-1:0]  a_q, b_q, rem_q, quo_q, result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             negq_q, negr_q;

  logic            is_signed, is_rem, div0, ovf, special, last_iter, qbit;
  logic [XLEN-1:0] abs_a, abs_b, rsh, quo_fix, rem_fix;

  assign is_signed = ~op_q[0];
  assign is_rem    = op_q[1];
  assign div0      = (b_q == '0);
  assign ovf       = is_signed && (a_q == INT_MIN) && (b_q == '1);
  assign special   = div0 | ovf;
  assign abs_a     = (is_signed && a_q[XLEN-1]) ? -a_q : a_q;
  assign abs_b     = (is_signed && b_q[XLEN-1]) ? -b_q : b_q;
  assign last_iter = (cnt_q == CNT_W'(XLEN-1));

  // rem_q[XLEN-1] is the 33rd bit of the shifted remainder: if set, the
  // shifted value certainly exceeds the divisor regardless of the ALU borrow.
  assign rsh     = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
  assign qbit    = rem_q[XLEN-1] | ~alu_carry_i;
  assign quo_fix = negq_q ? -quo_q : quo_q;
  assign rem_fix = negr_q ? -rem_q : rem_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = PREP;
      PREP:    state_d = special ? DONE : ITER;
      ITER:    if (last_iter) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_comb begin
    busy_o     = (state_q != IDLE);
    done_o     = (state_q == DONE);
    alu_a_o    = '0;
    alu_b_o    = '0;
    alu_ctrl_o = ALU_ADD;
    if (state_q == ITER) begin
      alu_a_o    = rsh;
      alu_b_o    = b_q;
      alu_ctrl_o = ALU_SUB;
    end
  end

  // Working registers; result_q only moves on a completed operation so a
  // flush leaves the previous answer visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i && !flush_i) begin
          op_q <= op_i;
          a_q  <= rs1_i;
          b_q  <= rs2_i;
        end
        PREP: begin
          if (div0) begin
            if (!flush_i) result_q <= is_rem ? a_q : '1;
          end else if (ovf) begin
            if (!flush_i) result_q <= is_rem ? '0 : INT_MIN;
          end else begin
            rem_q  <= '0;
            quo_q  <= abs_a;
            b_q    <= abs_b;
            cnt_q  <= '0;
            negq_q <= is_signed & (a_q[XLEN-1] ^ b_q[XLEN-1]);
            negr_q <= is_signed & a_q[XLEN-1];
          end
        end
        ITER: begin
          rem_q <= qbit ? alu_result_i : rsh;
          quo_q <= {quo_q[XLEN-2:0], qbit};
          cnt_q <= cnt_q + 1'b1;
        end
        FIX: if (!flush_i) result_q <= is_rem ? rem_fix : quo_fix;
        default: ;
      endcase
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Directed + small random bench for alu_div_sequencer with a behavioural EX ALU.
module tb_alu_div_sequencer;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start_i, flush_i;
  logic [1:0]  op_i;
  logic [31:0] rs1_i, rs2_i;
  logic        busy_o, done_o;
  logic [31:0] result_o, alu_a_o, alu_b_o, alu_result_i;
  logic [2:0]  alu_ctrl_o;
  logic        alu_carry_i;

  int checks = 0;
  int errors = 0;
  logic [31:0] last;

  always #5 clk = ~clk;

  alu_div_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_result_i(alu_result_i), .alu_carry_i(alu_carry_i)
  );

  // EX-stage ALU as the parent would supply it
  always_comb begin
    alu_result_i = alu_a_o + alu_b_o;
    alu_carry_i  = 1'b0;
    if (alu_ctrl_o == ALU_SUB) begin
      alu_result_i = alu_a_o - alu_b_o;
      alu_carry_i  = (alu_a_o < alu_b_o);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sg, rm;
    sg = ~op[0];
    rm = op[1];
    if (b == 32'h0) return rm ? a : 32'hFFFF_FFFF;
    if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rm ? 32'h0 : 32'h8000_0000;
    if (sg) return rm ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return rm ? a % b : a / b;
  endfunction

  // Returns during the DONE cycle so the next call starts back-to-back.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat, input bit poke);
    int k;
    @(posedge clk); #1;
    chk({tag, " idle"}, {31'b0, busy_o}, 32'd0);
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
    @(posedge clk); #1;
    start_i = 1'b0;
    k = 0;
    while (!done_o && k < 60) begin
      if (poke && k == 5) begin
        start_i = 1'b1; op_i = DIV_OP_DIVU; rs1_i = 32'h55; rs2_i = 32'h0;
      end else start_i = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    start_i = 1'b0;
    chk({tag, " lat"}, k + 1, lat);
    chk({tag, " res"}, result_o, exp);
    chk({tag, " busy"}, {31'b0, busy_o}, 32'd1);
    last = result_o;
  endtask

  initial begin
    logic        seen;
    logic [1:0]  rop;
    logic [31:0] ra, rb, rexp;
    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    op_i = 2'b00; rs1_i = '0; rs2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", {31'b0, busy_o}, 32'd0);
    chk("rst done", {31'b0, done_o}, 32'd0);
    chk("rst res", result_o, 32'd0);
    chk("rst alu_a", alu_a_o, 32'd0);
    chk("rst ctrl", {29'b0, alu_ctrl_o}, 32'd0);
    rst_n = 1'b1;

    run_op("divu 100/7",  DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 35, 1'b0);
    run_op("remu 100/7",  DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 35, 1'b0);
    run_op("div -7/2",    DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, 1'b0);
    run_op("rem -7/2",    DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, 1'b0);
    run_op("div 7/-2",    DIV_OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 35, 1'b0);
    run_op("divu msb",    DIV_OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 35, 1'b0);
    run_op("remu msb",    DIV_OP_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 35, 1'b0);
    run_op("divu 5/9",    DIV_OP_DIVU, 32'd5, 32'd9, 32'd0, 35, 1'b0);
    run_op("remu 5/9",    DIV_OP_REMU, 32'd5, 32'd9, 32'd5, 35, 1'b0);
    run_op("div by0",     DIV_OP_DIV, 32'h1234, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
    run_op("rem by0",     DIV_OP_REM, 32'h1234, 32'd0, 32'h1234, 2, 1'b0);
    run_op("div ovf",     DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1'b0);
    run_op("rem ovf",     DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, 1'b0);
    run_op("busy start",  DIV_OP_DIVU, 32'd1000, 32'd10, 32'd100, 35, 1'b1);

    // flush in the 10th ITER cycle
    @(posedge clk); #1;
    start_i = 1'b1; op_i = DIV_OP_DIVU; rs1_i = 32'd1000; rs2_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("iter ctrl", {29'b0, alu_ctrl_o}, {29'b0, ALU_SUB});
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush busy", {31'b0, busy_o}, 32'd0);
    chk("flush res", result_o, last);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= done_o;
    end
    chk("flush nodone", {31'b0, seen}, 32'd0);

    // flush beats start in IDLE
    start_i = 1'b1; flush_i = 1'b1; op_i = DIV_OP_DIV; rs1_i = 32'd9; rs2_i = 32'd0;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush+start", {31'b0, busy_o}, 32'd0);

    // reset mid-ITER
    start_i = 1'b1; op_i = DIV_OP_DIVU; rs1_i = 32'd77; rs2_i = 32'd5;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid rst busy", {31'b0, busy_o}, 32'd0);
    chk("mid rst res", result_o, 32'd0);
    chk("mid rst alu_b", alu_b_o, 32'd0);
    chk("mid rst ctrl", {29'b0, alu_ctrl_o}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? $urandom : ($urandom >> $urandom_range(8, 31));
      rexp = ref_div(rop, ra, rb);
      run_op("rand", rop, ra, rb, rexp,
             (rb == 0 || (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? 2 : 35, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
